csr_regfile: RTL and testbench

Machine-mode CSR register file for the RISC-V pipeline. It supplies CSR read data to the execute-stage CSR ALU, which combines it with the register operand. It then commits the ALU result at writeback. It also maintains the `mcycle` and `minstret` counters and performs the architectural CSR updates for trap entry and `mret`.

---
 rtl/csr_regfile.sv | 152 +++++++++++++++
 tb/tb_csr_regfile.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/csr_regfile.sv
// Machine-mode CSR file: combinational read port, one writeback write port,
// free-running mcycle/minstret, and trap-entry / mret updates of mstatus/mepc/mcause/mtval.
module csr_regfile #(
    parameter logic [63:0] HARTID = 64'd0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [11:0] ra,
    output logic [63:0] rd,
    output logic        r_illegal,
    input  logic        wvalid,
    input  logic [11:0] wa,
    input  logic [63:0] wd,
    input  logic        retire,
    input  logic        trap_valid,
    input  logic [63:0] trap_pc,
    input  logic [63:0] trap_cause,
    input  logic [63:0] trap_tval,
    input  logic        mret_valid,
    output logic [63:0] mtvec_o,
    output logic [63:0] mepc_o,
    output logic        mie_o
);

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;
    localparam logic [63:0] LOW2_MASK    = ~64'd3;

    logic        mie_bit_q, mie_bit_d;
    logic        mpie_q, mpie_d;
    logic [63:0] mie_q, mie_d;
    logic [63:0] mtvec_q, mtvec_d;
    logic [63:0] mscratch_q, mscratch_d;
    logic [63:0] mepc_q, mepc_d;
    logic [63:0] mcause_q, mcause_d;
    logic [63:0] mtval_q, mtval_d;
    logic [63:0] mip_q, mip_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic [63:0] mstatus_rd;
    // MPP is hardwired to M-mode; only MIE/MPIE are backed by storage.
    assign mstatus_rd = {51'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_bit_q, 3'd0};

    always_comb begin
        rd        = 64'd0;
        r_illegal = 1'b0;
        case (ra)
            CSR_MSTATUS:  rd = mstatus_rd;
            CSR_MIE:      rd = mie_q;
            CSR_MTVEC:    rd = mtvec_q;
            CSR_MSCRATCH: rd = mscratch_q;
            CSR_MEPC:     rd = mepc_q;
            CSR_MCAUSE:   rd = mcause_q;
            CSR_MTVAL:    rd = mtval_q;
            CSR_MIP:      rd = mip_q;
            CSR_MCYCLE:   rd = mcycle_q;
            CSR_MINSTRET: rd = minstret_q;
            CSR_MHARTID:  rd = HARTID;
            default:      r_illegal = 1'b1;
        endcase
    end

    // Lowest priority first; each later stage overrides what it touches.
    always_comb begin
        mie_bit_d  = mie_bit_q;
        mpie_d     = mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mip_d      = mip_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, retire};

        if (wvalid) begin
            case (wa)
                CSR_MSTATUS: begin
                    mie_bit_d = wd[3];
                    mpie_d    = wd[7];
                end
                CSR_MIE:      mie_d      = wd;
                CSR_MTVEC:    mtvec_d    = wd & LOW2_MASK;
                CSR_MSCRATCH: mscratch_d = wd;
                CSR_MEPC:     mepc_d     = wd & LOW2_MASK;
                CSR_MCAUSE:   mcause_d   = wd;
                CSR_MTVAL:    mtval_d    = wd;
                CSR_MIP:      mip_d      = wd;
                CSR_MCYCLE:   mcycle_d   = wd;
                CSR_MINSTRET: minstret_d = wd;
                default: ;
            endcase
        end

        if (mret_valid) begin
            mie_bit_d = mpie_q;
            mpie_d    = 1'b1;
        end

        if (trap_valid) begin
            mepc_d    = trap_pc & LOW2_MASK;
            mcause_d  = trap_cause;
            mtval_d   = trap_tval;
            mpie_d    = mie_bit_q;
            mie_bit_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mie_bit_q  <= 1'b0;
            mpie_q     <= 1'b0;
            mie_q      <= 64'd0;
            mtvec_q    <= 64'd0;
            mscratch_q <= 64'd0;
            mepc_q     <= 64'd0;
            mcause_q   <= 64'd0;
            mtval_q    <= 64'd0;
            mip_q      <= 64'd0;
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
        end else begin
            mie_bit_q  <= mie_bit_d;
            mpie_q     <= mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mip_q      <= mip_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign mtvec_o = mtvec_q;
    assign mepc_o  = mepc_q;
    assign mie_o   = mie_bit_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Scoreboard bench for csr_regfile: stimulus queues expectations, a negedge
// monitor pops and compares them against the selected DUT output.
module tb_csr_regfile;

    localparam logic [63:0] HART = 64'd3;
    localparam int K_RD = 0, K_ILL = 1, K_MTVEC = 2, K_MEPC = 3, K_MIE = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic [11:0] ra;
    logic [63:0] rd;
    logic        r_illegal;
    logic        wvalid;
    logic [11:0] wa;
    logic [63:0] wd;
    logic        retire;
    logic        trap_valid;
    logic [63:0] trap_pc, trap_cause, trap_tval;
    logic        mret_valid;
    logic [63:0] mtvec_o, mepc_o;
    logic        mie_o;

    csr_regfile #(.HARTID(HART)) dut (
        .clk(clk), .resetn(resetn), .ra(ra), .rd(rd), .r_illegal(r_illegal),
        .wvalid(wvalid), .wa(wa), .wd(wd), .retire(retire),
        .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
        .trap_tval(trap_tval), .mret_valid(mret_valid),
        .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_o(mie_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Monitor: outputs are settled at the negedge; drain all pending expectations.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                exp_t e;
                logic [63:0] act;
                e = q.pop_front();
                case (e.kind)
                    K_RD:    act = rd;
                    K_ILL:   act = {63'd0, r_illegal};
                    K_MTVEC: act = mtvec_o;
                    K_MEPC:  act = mepc_o;
                    default: act = {63'd0, mie_o};
                endcase
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input logic [11:0] a, input logic [63:0] exp, input string name);
        exp_t e;
        ra = a;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic chk(input int kind, input logic [11:0] a, input logic [63:0] exp, input string name);
        push(kind, a, exp, name);
        tick();
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
        wvalid = 1'b1; wa = a; wd = d;
        tick();
        wvalid = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; ra = 12'h300; wvalid = 1'b0; wa = '0; wd = '0; retire = 1'b0;
        trap_valid = 1'b0; trap_pc = '0; trap_cause = '0; trap_tval = '0; mret_valid = 1'b0;
        tick();
        tick();

        // Reset state
        chk(K_RD,    12'h300, 64'h1800, "rst_mstatus");
        chk(K_MTVEC, 12'h300, 64'd0,    "rst_mtvec_o");
        chk(K_MEPC,  12'h300, 64'd0,    "rst_mepc_o");
        chk(K_MIE,   12'h300, 64'd0,    "rst_mie_o");
        chk(K_RD,    12'hB00, 64'd0,    "rst_mcycle");

        // Release, then 10 edges -> mcycle reads 10
        resetn = 1'b1;
        repeat (10) tick();
        chk(K_RD, 12'hB00, 64'd10, "mcycle_10");

        csr_write(12'h340, 64'hDEADBEEF_CAFEF00D);
        chk(K_RD,  12'h340, 64'hDEADBEEF_CAFEF00D, "mscratch_wr");
        chk(K_RD,  12'hF14, HART,  "mhartid");
        chk(K_RD,  12'h7C0, 64'd0, "unimpl_rd");
        chk(K_ILL, 12'h7C0, 64'd1, "unimpl_illegal");
        chk(K_ILL, 12'h340, 64'd0, "impl_legal");

        // Write masking
        csr_write(12'h305, 64'h8000_0003);
        chk(K_RD,    12'h305, 64'h8000_0000, "mtvec_mask");
        chk(K_MTVEC, 12'h305, 64'h8000_0000, "mtvec_o");
        csr_write(12'h300, '1);
        chk(K_RD,  12'h300, 64'h1888, "mstatus_mask");
        chk(K_MIE, 12'h300, 64'd1,    "mie_o_set");
        csr_write(12'hF14, 64'd5);
        chk(K_RD, 12'hF14, HART, "mhartid_ro");
        csr_write(12'h7C0, 64'h55);
        chk(K_RD, 12'h7C0, 64'd0, "unimpl_wr_drop");

        // minstret
        chk(K_RD, 12'hB02, 64'd0, "minstret_0");
        retire = 1'b1;
        repeat (3) tick();
        retire = 1'b0;
        chk(K_RD, 12'hB02, 64'd3, "minstret_3");
        retire = 1'b1;
        csr_write(12'hB02, 64'd100);
        retire = 1'b0;
        chk(K_RD, 12'hB02, 64'd100, "minstret_wr_retire");

        // mcycle wrap
        csr_write(12'hB00, '1);
        chk(K_RD, 12'hB00, '1,    "mcycle_max");
        chk(K_RD, 12'hB00, 64'd0, "mcycle_wrap");
        chk(K_RD, 12'hB00, 64'd1, "mcycle_after_wrap");

        // Trap with MIE=1, MPIE=0
        csr_write(12'h300, 64'h8);
        trap_valid = 1'b1; trap_pc = 64'h8000_0106; trap_cause = 64'd2; trap_tval = 64'h13;
        tick();
        trap_valid = 1'b0;
        chk(K_RD,   12'h341, 64'h8000_0104, "trap_mepc");
        chk(K_MEPC, 12'h341, 64'h8000_0104, "trap_mepc_o");
        chk(K_RD,   12'h342, 64'd2,         "trap_mcause");
        chk(K_RD,   12'h343, 64'h13,        "trap_mtval");
        chk(K_RD,   12'h300, 64'h1880,      "trap_mstatus");
        chk(K_MIE,  12'h300, 64'd0,         "trap_mie_o");
        mret_valid = 1'b1;
        tick();
        mret_valid = 1'b0;
        chk(K_RD,  12'h300, 64'h1888, "mret_mstatus");
        chk(K_MIE, 12'h300, 64'd1,    "mret_mie_o");

        // Collision: trap + mret + write to mepc -> trap wins
        trap_valid = 1'b1; mret_valid = 1'b1; trap_pc = 64'h2002;
        trap_cause = 64'h8000_0000_0000_000B; trap_tval = 64'h55;
        csr_write(12'h341, 64'h1234_5678);
        trap_valid = 1'b0; mret_valid = 1'b0;
        chk(K_RD, 12'h341, 64'h2000,                "col_mepc");
        chk(K_RD, 12'h342, 64'h8000_0000_0000_000B, "col_mcause");
        chk(K_RD, 12'h343, 64'h55,                  "col_mtval");
        chk(K_RD, 12'h300, 64'h1880,                "col_mstatus");

        // Trap + write to untouched mscratch -> write commits
        trap_valid = 1'b1; trap_pc = 64'h3000; trap_cause = 64'd7; trap_tval = 64'd0;
        csr_write(12'h340, 64'h77);
        trap_valid = 1'b0;
        chk(K_RD, 12'h340, 64'h77,   "col_mscratch");
        chk(K_RD, 12'h341, 64'h3000, "col2_mepc");
        chk(K_RD, 12'h300, 64'h1800, "col2_mstatus");

        // mret + write to mstatus -> mret wins (MPIE=0 -> MIE=0, MPIE=1)
        mret_valid = 1'b1;
        csr_write(12'h300, 64'h8);
        mret_valid = 1'b0;
        chk(K_RD, 12'h300, 64'h1880, "mret_vs_wr");

        // Async reset between edges with counters nonzero
        csr_write(12'h300, 64'h8);
        retire = 1'b1;
        tick();
        retire = 1'b0;
        #2;
        resetn = 1'b0;
        push(K_RD,    12'hB00, 64'd0, "arst_mcycle");
        push(K_MTVEC, 12'hB00, 64'd0, "arst_mtvec_o");
        push(K_MEPC,  12'hB00, 64'd0, "arst_mepc_o");
        push(K_MIE,   12'hB00, 64'd0, "arst_mie_o");
        tick();
        chk(K_RD, 12'hB02, 64'd0,    "arst_minstret");
        chk(K_RD, 12'h340, 64'd0,    "arst_mscratch");
        chk(K_RD, 12'h300, 64'h1800, "arst_mstatus");
        resetn = 1'b1;
        tick();

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
